// File: rtl/cga_vram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cga_vram_arbiter: CPU/display VRAM arbiter; CGA_SNOW_EN selects snow mode |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module cga_vram_arbiter #(
  parameter int unsigned ACC_CYCLES = 2,
  parameter logic [3:0]  ADDR_HI    = 4'h0
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        vram_read,
  input  logic [18:0] disp_addr,
  input  logic        cpu_cs,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  ram_d,
  output logic [18:0] ram_a,
  output logic        ram_we_l,
  output logic [7:0]  ram_dout,
  output logic [7:0]  cpu_rdata,
  output logic        bus_rdy,
  output logic        cpu_grant,
  output logic        snow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [2:0] C_LAST_BEAT = 3'(ACC_CYCLES - 1);

  state_t      r_state;
  logic [2:0]  r_count;
  logic [1:0]  r_mr_sync;
  logic [1:0]  r_mw_sync;
  logic [14:0] r_addr;
  logic [7:0]  r_data;
  logic        r_write;

  logic w_mr_s;
  logic w_mw_s;
  logic w_abort;
  logic w_wait_go;
  logic w_own;

  // Strobes come straight off the ISA bus; sync resets to the idle (high) level.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_mr_sync <= 2'b11;
      r_mw_sync <= 2'b11;
    end else begin
      r_mr_sync <= {r_mr_sync[0], bus_memr_l};
      r_mw_sync <= {r_mw_sync[0], bus_memw_l};
    end
  end

  assign w_mr_s = r_mr_sync[1];
  assign w_mw_s = r_mw_sync[1];

`ifdef CGA_SNOW_EN
  // CPU always barges in; the display sees corrupted data ("snow") instead.
  assign w_abort   = 1'b0;
  assign w_wait_go = 1'b1;
  assign snow      = w_own & vram_read;
`else
  assign w_abort   = vram_read;
  assign w_wait_go = ~vram_read;
  assign snow      = 1'b0;
`endif

  // Ownership is combinational so a display fetch takes the RAM in the same cycle.
  assign w_own     = (r_state == S_ACCESS) & ~w_abort;
  assign cpu_grant = w_own;
  assign ram_a     = w_own ? {ADDR_HI, r_addr} : disp_addr;
  assign ram_we_l  = ~(w_own & r_write);
  assign ram_dout  = r_data;
  assign bus_rdy   = (r_state == S_IDLE) | (r_state == S_HOLD);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_write   <= 1'b0;
      cpu_rdata <= 8'h00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Both strobes low at once is a bus fault; ignore it.
          if (cpu_cs && (w_mr_s ^ w_mw_s)) begin
            r_addr  <= cpu_addr;
            r_data  <= cpu_wdata;
            r_write <= ~w_mw_s;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_wait_go) begin
            r_count <= '0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_abort) begin
            r_count <= '0;
            r_state <= S_WAIT;
          end else if (r_count == C_LAST_BEAT) begin
            if (!r_write) begin
              cpu_rdata <= ram_d;
            end
            r_state <= S_HOLD;
          end else begin
            r_count <= r_count + 3'd1;
          end
        end
        S_HOLD: begin
          // Wait for the strobe to go away so one strobe gives one access.
          if (w_mr_s && w_mw_s) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
